// File: rtl/branch_unit_bp_if.sv
// Bundle between the core and branch_unit_bp: fetch-side prediction query,
// back-end resolution request, registered result and statistics.
interface branch_unit_bp_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  pred_pc;
  logic             pred_taken;
  logic             res_valid;
  logic [4:0]       res_opcode;
  logic [XLEN-1:0]  res_rs1;
  logic [XLEN-1:0]  res_rs2;
  logic [XLEN-1:0]  res_pc;
  logic [XLEN-1:0]  res_imm;
  logic             res_pred_taken;
  logic             out_valid;
  logic             out_taken;
  logic [XLEN-1:0]  out_target;
  logic             out_mispredict;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;

  modport master (
    output pred_pc, res_valid, res_opcode, res_rs1, res_rs2, res_pc, res_imm,
           res_pred_taken,
    input  pred_taken, out_valid, out_taken, out_target, out_mispredict,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  pred_pc, res_valid, res_opcode, res_rs1, res_rs2, res_pc, res_imm,
           res_pred_taken,
    output pred_taken, out_valid, out_taken, out_target, out_mispredict,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_unit_bp.sv
// Branch resolution unit with a 2-bit saturating-counter direction predictor,
// registered taken/target/mispredict result and saturating event counters.
module branch_unit_bp #(
  parameter int XLEN    = 32,
  parameter int BHT_IDX = 6,
  parameter int CNT_W   = 16
) (
  input logic             clk,
  input logic             rst,
  branch_unit_bp_if.slave bus
);
  localparam int ENTRIES = 2 ** BHT_IDX;

  typedef enum logic [4:0] {
    OP_EQ    = 5'b00000,
    OP_NE    = 5'b00001,
    OP_LT    = 5'b00100,
    OP_GE    = 5'b00101,
    OP_LTU   = 5'b00110,
    OP_GEU   = 5'b00111,
    OP_JAL   = 5'b01111,
    OP_JALR  = 5'b10111,
    OP_NEVER = 5'b11111,
    OP_NOP   = 5'b10101
  } op_e;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  ctr_e bht [ENTRIES];

  logic [BHT_IDX-1:0] query_idx;
  logic [BHT_IDX-1:0] update_idx;

  logic            eq;
  logic            lt;
  logic            ltu;
  logic            taken;
  logic            is_cond;
  logic            mispredict;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jalr_sum;

  assign query_idx      = bus.pred_pc[BHT_IDX+1:2];
  assign update_idx     = bus.res_pc[BHT_IDX+1:2];
  // Reads the table as it stands before this cycle's update: no bypass.
  assign bus.pred_taken = bht[query_idx][1];

  assign eq       = (bus.res_rs1 == bus.res_rs2);
  assign lt       = ($signed(bus.res_rs1) < $signed(bus.res_rs2));
  assign ltu      = (bus.res_rs1 < bus.res_rs2);
  assign jalr_sum = bus.res_rs1 + bus.res_imm;

  // NOTE: every output of this block gets a default first so no path
  // through the case statement can leave a value unassigned (latch).
  always_comb begin
    taken   = 1'b0;
    is_cond = 1'b0;
    target  = bus.res_pc + XLEN'(4);
    case (bus.res_opcode)
      OP_EQ:   begin is_cond = 1'b1; taken = eq;   end
      OP_NE:   begin is_cond = 1'b1; taken = !eq;  end
      OP_LT:   begin is_cond = 1'b1; taken = lt;   end
      OP_GE:   begin is_cond = 1'b1; taken = !lt;  end
      OP_LTU:  begin is_cond = 1'b1; taken = ltu;  end
      OP_GEU:  begin is_cond = 1'b1; taken = !ltu; end
      OP_JAL:  taken = 1'b1;
      OP_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    if (bus.res_opcode == OP_JALR) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (taken) begin
      target = bus.res_pc + bus.res_imm;
    end
  end

  assign mispredict = (taken != bus.res_pred_taken);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.out_taken      <= 1'b0;
      bus.out_target     <= '0;
      bus.out_mispredict <= 1'b0;
    end else begin
      bus.out_valid <= bus.res_valid;
      if (bus.res_valid) begin
        bus.out_taken      <= taken;
        bus.out_target     <= target;
        bus.out_mispredict <= mispredict;
      end
    end
  end

  // NOTE: the predictor table is reset on purpose: every entry must start
  // weakly-not-taken, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= CTR_WNT;
      end
    end else if (bus.res_valid && is_cond) begin
      if (taken && bht[update_idx] != CTR_ST) begin
        bht[update_idx] <= ctr_e'(bht[update_idx] + 2'd1);
      end else if (!taken && bht[update_idx] != CTR_SNT) begin
        bht[update_idx] <= ctr_e'(bht[update_idx] - 2'd1);
      end
    end
  end

  // Statistics saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.stat_branches    <= '0;
      bus.stat_mispredicts <= '0;
    end else if (bus.res_valid) begin
      if (is_cond && bus.stat_branches != '1) begin
        bus.stat_branches <= bus.stat_branches + CNT_W'(1);
      end
      if (mispredict && bus.stat_mispredicts != '1) begin
        bus.stat_mispredicts <= bus.stat_mispredicts + CNT_W'(1);
      end
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc[XLEN-1:BHT_IDX+2], bus.pred_pc[1:0]};

endmodule

// File: tb/tb_branch_unit_bp.sv
// Directed scoreboard bench for branch_unit_bp: default instance plus a
// CNT_W=4 instance for statistics saturation.
module tb_branch_unit_bp;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
    logic            mispredict;
    logic            cond;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_unit_bp_if #(.XLEN(XLEN), .CNT_W(16)) bus ();
  branch_unit_bp_if #(.XLEN(XLEN), .CNT_W(4))  bs ();

  branch_unit_bp #(.XLEN(XLEN), .BHT_IDX(6), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  branch_unit_bp #(.XLEN(XLEN), .BHT_IDX(6), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .bus(bs.slave)
  );

  exp_t        sb[$];
  logic [1:0]  m_bht[64];
  logic [15:0] m_br;
  logic [15:0] m_mp;
  exp_t        last;
  int          n_checks = 0;
  int          n_bad    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] rs1, rs2, pc, imm,
                                 input logic pred);
    exp_t e;
    e.cond  = 1'b0;
    e.taken = 1'b0;
    case (op)
      5'b00000: begin e.cond = 1'b1; e.taken = (rs1 == rs2); end
      5'b00001: begin e.cond = 1'b1; e.taken = (rs1 != rs2); end
      5'b00100: begin e.cond = 1'b1; e.taken = ($signed(rs1) <  $signed(rs2)); end
      5'b00101: begin e.cond = 1'b1; e.taken = ($signed(rs1) >= $signed(rs2)); end
      5'b00110: begin e.cond = 1'b1; e.taken = (rs1 <  rs2); end
      5'b00111: begin e.cond = 1'b1; e.taken = (rs1 >= rs2); end
      5'b01111, 5'b10111: e.taken = 1'b1;
      default: e.taken = 1'b0;
    endcase
    if (op == 5'b10111)  e.target = (rs1 + imm) & ~32'd1;
    else if (e.taken)    e.target = pc + imm;
    else                 e.target = pc + 32'd4;
    e.mispredict = (e.taken != pred);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_br = '0;
    m_mp = '0;
    sb.delete();
  endtask

  // One resolution request: drive, check the pre-update prediction, then
  // check the registered result, stats and post-update prediction.
  task automatic send(input logic [4:0] op, input logic [31:0] rs1, rs2, pc, imm,
                      input logic pred);
    exp_t       e;
    logic [5:0] idx;
    bus.res_valid      = 1'b1;
    bus.res_opcode     = op;
    bus.res_rs1        = rs1;
    bus.res_rs2        = rs2;
    bus.res_pc         = pc;
    bus.res_imm        = imm;
    bus.res_pred_taken = pred;
    e = model(op, rs1, rs2, pc, imm, pred);
    sb.push_back(e);
    idx = pc[7:2];
    @(negedge clk);
    check("pred_pre", 64'(bus.pred_taken), 64'(m_bht[bus.pred_pc[7:2]][1]));
    @(posedge clk);
    if (e.cond) begin
      if (e.taken && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'd1;
      if (!e.taken && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'd1;
      if (m_br != 16'hFFFF) m_br++;
    end
    if (e.mispredict && m_mp != 16'hFFFF) m_mp++;
    #1;
    check("out_valid", 64'(bus.out_valid), 64'd1);
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      last = e;
      check("out_taken",      64'(bus.out_taken),      64'(e.taken));
      check("out_target",     64'(bus.out_target),     64'(e.target));
      check("out_mispredict", 64'(bus.out_mispredict), 64'(e.mispredict));
    end
    check("stat_branches",    64'(bus.stat_branches),    64'(m_br));
    check("stat_mispredicts", 64'(bus.stat_mispredicts), 64'(m_mp));
    check("pred_post", 64'(bus.pred_taken), 64'(m_bht[bus.pred_pc[7:2]][1]));
  endtask

  task automatic idle();
    bus.res_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_valid",  64'(bus.out_valid),      64'd0);
    check("idle_taken",  64'(bus.out_taken),      64'(last.taken));
    check("idle_target", 64'(bus.out_target),     64'(last.target));
    check("idle_misp",   64'(bus.out_mispredict), 64'(last.mispredict));
  endtask

  initial begin
    bus.pred_pc = 32'h100; bus.res_valid = 1'b0; bus.res_opcode = '0;
    bus.res_rs1 = '0; bus.res_rs2 = '0; bus.res_pc = '0; bus.res_imm = '0;
    bus.res_pred_taken = 1'b0;
    bs.pred_pc = '0; bs.res_valid = 1'b0; bs.res_opcode = '0;
    bs.res_rs1 = '0; bs.res_rs2 = '0; bs.res_pc = '0; bs.res_imm = '0;
    bs.res_pred_taken = 1'b0;
    model_reset();
    last = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pred",   64'(bus.pred_taken),       64'd0);
    check("rst_valid",  64'(bus.out_valid),        64'd0);
    check("rst_taken",  64'(bus.out_taken),        64'd0);
    check("rst_target", 64'(bus.out_target),       64'd0);
    check("rst_misp",   64'(bus.out_mispredict),   64'd0);
    check("rst_br",     64'(bus.stat_branches),    64'd0);
    check("rst_mp",     64'(bus.stat_mispredicts), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // EQ taken at pc 0x100: target 0x120, mispredict, counter 01 -> 10
    send(5'b00000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    check("eq_target_const", 64'(bus.out_target), 64'h120);
    check("eq_pred_const",   64'(bus.pred_taken), 64'd1);
    idle();

    // Signed vs unsigned compares, back-to-back
    send(5'b00100, 32'hFFFF_FFFF, 32'd1, 32'h204, 32'h10, 1'b0);
    send(5'b00110, 32'hFFFF_FFFF, 32'd1, 32'h208, 32'h10, 1'b0);
    check("ltu_target_const", 64'(bus.out_target), 64'h20C);
    send(5'b00111, 32'hFFFF_FFFF, 32'd1, 32'h20C, 32'hFFFF_FFF0, 1'b1);
    send(5'b00101, 32'hFFFF_FFFF, 32'd1, 32'h210, 32'h8, 1'b1);
    send(5'b00001, 32'd7, 32'd9, 32'h214, 32'h40, 1'b1);
    idle();

    // Training at pc 0x40: query and update the same index every cycle
    bus.pred_pc = 32'h40;
    for (int i = 0; i < 4; i++) send(5'b00000, 32'd1, 32'd1, 32'h40, 32'h8, bus.pred_taken);
    check("train_taken_const", 64'(bus.pred_taken), 64'd1);
    for (int i = 0; i < 3; i++) send(5'b00001, 32'd1, 32'd1, 32'h40, 32'h8, bus.pred_taken);
    check("train_nt_const", 64'(bus.pred_taken), 64'd0);
    send(5'b00000, 32'd2, 32'd2, 32'h40, 32'h8, 1'b0);
    check("floor_const", 64'(bus.pred_taken), 64'd0);

    // Unconditional and never-taken codes
    send(5'b10111, 32'h1001, 32'd0, 32'h300, 32'd4, 1'b1);
    check("jalr_target_const", 64'(bus.out_target), 64'h1004);
    send(5'b01111, 32'd0, 32'd0, 32'h300, 32'h80, 1'b0);
    send(5'b11111, 32'd3, 32'd3, 32'h304, 32'h80, 1'b1);
    send(5'b10101, 32'd3, 32'd3, 32'h308, 32'h80, 1'b0);
    idle();

    // Reset asserted while a request is presented
    bus.pred_pc        = 32'h100;
    bus.res_valid      = 1'b1;
    bus.res_opcode     = 5'b00000;
    bus.res_rs1        = 32'd1;
    bus.res_rs2        = 32'd1;
    bus.res_pc         = 32'h100;
    bus.res_pred_taken = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid),     64'd0);
    check("mid_rst_pred",  64'(bus.pred_taken),    64'd0);
    check("mid_rst_br",    64'(bus.stat_branches), 64'd0);
    @(posedge clk);
    #1;
    check("mid_rst_valid2", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.res_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    send(5'b00000, 32'd1, 32'd1, 32'h100, 32'h20, 1'b0);
    check("post_rst_pred_const", 64'(bus.pred_taken), 64'd1);
    idle();

    // Statistics saturation on the CNT_W=4 instance
    bs.res_opcode     = 5'b00000;
    bs.res_rs1        = 32'd3;
    bs.res_rs2        = 32'd3;
    bs.res_pc         = 32'h80;
    bs.res_imm        = 32'h10;
    bs.res_pred_taken = 1'b0;
    bs.res_valid      = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 15) begin
        check("sat15_br", 64'(bs.stat_branches),    64'd15);
        check("sat15_mp", 64'(bs.stat_mispredicts), 64'd15);
      end
    end
    bs.res_valid = 1'b0;
    check("sat_br",   64'(bs.stat_branches),    64'd15);
    check("sat_mp",   64'(bs.stat_mispredicts), 64'd15);
    check("sat_misp", 64'(bs.out_mispredict),   64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
